// File: rtl/adder_share_arb_pkg.sv
// adder_share_arb_pkg: shared widths, tag type and index helper for the shared-adder arbiter
package adder_share_arb_pkg;

    localparam int DATA_W  = 16;
    localparam int SUM_W   = DATA_W + 1;
    localparam int ADD_LAT = 2;
    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// rr_arbiter: round-robin priority search starting at ptr, one-hot grant plus encoded index
module rr_arbiter
    import adder_share_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest requester at or after ptr wins
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            grant = (en && req[wrap_add(int'(ptr), k, N)]) ? N'(1) << wrap_add(int'(ptr), k, N) : grant;
            idx   = (en && req[wrap_add(int'(ptr), k, N)]) ? IW'(wrap_add(int'(ptr), k, N)) : idx;
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: shares one pipelined adder among requesters, tagging ops and routing sums back
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = adder_share_arb_pkg::DATA_W,
    parameter int ADD_LAT = adder_share_arb_pkg::ADD_LAT
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]      req_a,
    input  logic [NUM_REQ*DATA_W-1:0]      req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_W-1:0]              add_a,
    output logic [DATA_W-1:0]              add_b,
    input  logic [DATA_W:0]                add_sum,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W:0]                rsp_sum,
    output logic [$clog2(ADD_LAT+1)-1:0]   inflight
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(ADD_LAT + 1);

    logic [IW-1:0]      r_ptr;
    tag_t               r_tag [ADD_LAT];
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W:0]    r_rsp_sum;
    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic [CW-1:0]      w_cnt;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .en    (enable & ~reset),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign w_any     = |w_grant;
    assign req_ready = w_grant;
    assign add_a     = w_any ? req_a[w_idx*DATA_W +: DATA_W] : '0;
    assign add_b     = w_any ? req_b[w_idx*DATA_W +: DATA_W] : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign inflight  = w_cnt;

    // Priority pointer moves just past the requester served on each grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_ptr <= '0;
        else
            r_ptr <= w_any ? ((w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1) : r_ptr;
    end

    // Requester tags shift alongside the adder stages; the adder never stalls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < ADD_LAT; k++)
                r_tag[k] <= '0;
        end else begin
            r_tag[0] <= {w_any, ID_W'(w_idx)};
            for (int k = 1; k < ADD_LAT; k++)
                r_tag[k] <= r_tag[k-1];
        end
    end

    // Sum is captured with its owner's strobe; the sum holds between strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
        end else begin
            r_rsp_valid <= r_tag[ADD_LAT-1].valid ? NUM_REQ'(1) << r_tag[ADD_LAT-1].id : '0;
            r_rsp_sum   <= r_tag[ADD_LAT-1].valid ? add_sum : r_rsp_sum;
        end
    end

    // Operations in flight: live tag stages plus a pending response strobe
    always_comb begin
        w_cnt = CW'(|r_rsp_valid);
        for (int k = 0; k < ADD_LAT; k++)
            w_cnt = w_cnt + CW'(r_tag[k].valid);
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: randomized and directed checks of the shared-adder arbiter against a queue model
module tb_adder_share_arb;

    localparam int N = 4;
    localparam int W = 16;
    localparam int L = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W:0]     add_sum;
    logic [N-1:0]   rsp_valid;
    logic [W:0]     rsp_sum;
    logic [1:0]     inflight;
    logic [W:0]     s1;
    logic [W:0]     s2;

    typedef struct {
        int         due;
        int         id;
        logic [W:0] sum;
    } op_t;

    op_t        q[$];
    int         m_ptr = 0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         max_infl = 0;
    logic [W:0] last_sum = '0;

    adder_share_arb #(.NUM_REQ(N), .DATA_W(W), .ADD_LAT(L)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .inflight  (inflight)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {1'b0, add_a} + {1'b0, add_b};
            s2 <= s1;
        end
    end
    assign add_sum = s2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    task automatic step();
        int           g;
        int           infl;
        logic [N-1:0] exp_rv;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        #1;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && enable && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        ea = (g >= 0) ? req_a[g*W +: W] : '0;
        eb = (g >= 0) ? req_b[g*W +: W] : '0;
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("add_a", 32'(add_a), 32'(ea));
        chk("add_b", 32'(add_b), 32'(eb));
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_rv = '0;
        infl   = 0;
        foreach (q[i]) begin
            if (q[i].due == cyc) begin
                exp_rv[q[i].id] = 1'b1;
                last_sum = q[i].sum;
            end
            if (q[i].due >= cyc) infl++;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("rsp_sum", 32'(rsp_sum), 32'(last_sum));
        chk("inflight", 32'(inflight), 32'(infl));
        if (int'(inflight) > max_infl) max_infl = int'(inflight);
        if (g >= 0) begin
            q.push_back('{due: cyc + 1 + L, id: g, sum: {1'b0, ea} + {1'b0, eb}});
            m_ptr = (g + 1) % N;
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic reset_pulse(input int n);
        reset     = 1'b1;
        enable    = 1'b1;
        req_valid = '1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        repeat (n) begin
            @(posedge clock);
            cyc++;
        end
        #1;
        reset     = 1'b0;
        req_valid = '0;
        q.delete();
        m_ptr    = 0;
        last_sum = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock);
        #1;
        reset_pulse(2);
        enable = 1'b1;
        repeat (5) step();

        set_req(2, 16'd199, 16'd1);
        step();
        req_valid = '0;
        repeat (4) step();

        reset_pulse(1);
        enable = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 16'(i * 100), 16'd1);
        max_infl = 0;
        repeat (12) step();
        chk("infl_max", 32'(max_infl), 32'(L + 1));
        req_valid = '0;
        repeat (4) step();

        set_req(1, 16'hFFFF, 16'h0001);
        step();
        req_valid = '0;
        repeat (4) step();

        reset_pulse(1);
        enable = 1'b1;
        set_req(0, 16'd1990, 16'd183);
        set_req(3, 16'd199, 16'd100);
        repeat (2) step();
        enable = 1'b0;
        repeat (5) step();
        chk("drain_inflight", 32'(inflight), 32'd0);
        req_valid = '0;

        enable = 1'b1;
        set_req(1, 16'd5, 16'd5);
        step();
        req_valid = '0;
        reset_pulse(1);
        enable = 1'b1;
        repeat (5) step();
        for (int i = 0; i < N; i++) set_req(i, 16'(i + 7), 16'(i * 3));
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        repeat (4) step();

        repeat (400) begin
            enable    = ($urandom_range(0, 9) != 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                req_b[i*W +: W] = 16'($urandom);
            end
            if ($urandom_range(0, 63) == 0) reset_pulse(1);
            else step();
        end
        req_valid = '0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one pipelined 16-bit adder (the two-stage registered adder, operands in, 17-bit sum out) between NUM_REQ requesters.
- Round-robin arbiter issues at most one operation per cycle to the adder.
- Tracks the requester ID of each in-flight operation through a tag pipeline matched to the adder latency.
- Returns each sum to its originating requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, operand width; sum width is DATA_W+1
- ADD_LAT, 2, adder latency in clock edges from operands at adder inputs to sum at adder output

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  when low, no new grants; in-flight operations still drain
- req_valid  input  NUM_REQ  per-requester operation request
- req_a  input  NUM_REQ*DATA_W  packed operand A, requester i at bits [i*DATA_W +: DATA_W]
- req_b  input  NUM_REQ*DATA_W  packed operand B, same packing
- req_ready  output  NUM_REQ  one-hot grant; request accepted when valid&ready
- add_a  output  DATA_W  operand A to shared adder
- add_b  output  DATA_W  operand B to shared adder
- add_sum  input  DATA_W+1  sum from shared adder
- rsp_valid  output  NUM_REQ  one-hot, one-cycle result strobe
- rsp_sum  output  DATA_W+1  result, valid when any rsp_valid bit is high
- inflight  output  clog2(ADD_LAT+1)  number of operations in the adder pipeline

Behaviour:
- Reset state (asynchronous): rr_ptr=0, all tag stages invalid, rsp_valid=0, rsp_sum=0, inflight=0. Combinational outputs: req_ready=0 and add_a/add_b=0 while reset is high.
- Arbitration is combinational within the cycle:
  - Search req_valid starting at index rr_ptr, ascending with wrap-around.
  - The first set bit i gets req_ready[i]=1, only if enable=1.
  - Otherwise req_ready=0.
  - req_ready never depends on anything except req_valid, rr_ptr, enable and reset.
- Issue: in a grant cycle, add_a/add_b = req_a/req_b slice of the granted requester. With no grant, add_a/add_b=0.
- On each accepting edge:
  - rr_ptr <= (i+1) mod NUM_REQ.
  - Tag stage 0 <= {valid=1, id=i}.
  - Without a grant, rr_ptr holds and stage 0 <= invalid.
- Tag pipeline: ADD_LAT stages that shift every cycle, unconditionally (the adder has no stall).
- Response: when the last tag stage is valid with id=k:
  - rsp_valid[k]=1 and rsp_sum=add_sum, both registered.
  - The strobe appears ADD_LAT+1 edges after the accepting edge.
- There is no response backpressure; requesters must take rsp_sum on the strobe cycle. rsp_sum holds its last value when rsp_valid=0.
- Throughput: one operation per cycle sustained. Back-to-back grants to the same requester are allowed only when it is the sole valid requester.
- inflight = count of valid tag stages plus the pending response register. It increments on grant, decrements on response, and does both in the same cycle when they coincide.
- enable falling mid-stream: no new grants; all in-flight results are still delivered. rr_ptr is unchanged.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them. The shared adder is reset by the same reset.
- Sum width: the full DATA_W+1 bits pass through; no truncation or saturation.

Decomposition:
- Shared package holds:
  - constant DATA_W=16, SUM_W=DATA_W+1, default ADD_LAT=2;
  - typedef for a tag struct {valid, id[clog2(NUM_REQ)-1:0]}.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin priority search, with inputs req, ptr, en and one-hot grant plus encoded index out. Reused by later shared-resource blocks.
- The tag pipeline and response register stay in adder_share_arb.
- Top-level integration instantiates adder_share_arb plus the shared adder, with add_a/add_b/add_sum wired directly.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then req_valid=0 for 5 cycles -> req_ready=0, rsp_valid=0, inflight=0, add_a=add_b=0 throughout.
- Single op: requester 2 asserts a=199, b=1 for one cycle, enable=1 -> req_ready=4'b0100 that cycle; ADD_LAT+1 edges later rsp_valid=4'b0100 for exactly one cycle with rsp_sum=200.
- Round-robin fairness: all four valid continuously with a=i*100, b=1 from rr_ptr=0 -> grants 0,1,2,3,0,... one per cycle; responses in the same order with sums 1,101,201,301 back-to-back; inflight saturates at ADD_LAT+1.
- Carry out: requester 1 with a=16'hFFFF, b=16'h0001 -> rsp_sum=17'h10000 on rsp_valid[1].
- Enable drop: two ops issued (req 0: 1990+183; req 3: 199+100), then enable=0 while req_valid stays high -> no further req_ready; still receive 2173 on rsp_valid[0] and 299 on rsp_valid[3]; inflight returns to 0.
- Reset mid-flight: grant req 1 (5+5), assert reset one cycle later -> no rsp_valid ever for that op, inflight=0 and rr_ptr=0 immediately; the next request from req 0 is granted first.
